tag_flag_ram_assoc: RTL and testbench
=====================================

// Module: tag_flag_ram_assoc
// PURPOSE
//   N-way set-associative cache tag/flag store with valid+dirty bits per way, parallel tag compare,
//   victim selection (first invalid way, else per-set round-robin) and a hardware invalidate sweep.
//   Successor to the direct-mapped read-only tag store; serves the I-cache and the write-back D-cache.
//   Sits between the cache controller FSM and one RAM_SP_ZI instance per way.
// PARAMETERS
//   PABITS       36  physical address width
//   INDEX_BITS   8   set index width; sets = 2**INDEX_BITS
//   OFFSET_BITS  4   line offset width; TAG_W = PABITS-INDEX_BITS-OFFSET_BITS (24 at defaults)
//   WAYS         2   associativity; power of two, 1..8; WAY_W = max(1,log2(WAYS))
// PORTS
//   clock         in   1           rising-edge clock
//   reset         in   1           asynchronous, active-low reset
//   Index         in   INDEX_BITS  set index for Lookup or Write
//   Lookup        in   1           start compare of set Index
//   Tag_Cmp       in   TAG_W       compare tag; sampled the cycle AFTER Lookup
//   Write         in   1           write {Valid,Dirty,Tag_Set} into way Write_Way of set Index
//   Write_Way     in   WAY_W       target way of Write
//   Tag_Set       in   TAG_W       tag to write
//   Valid         in   1           valid bit to write
//   Dirty         in   1           dirty bit to write
//   Invalidate_All in  1           pulse: clear every valid/dirty bit and round-robin pointer
//   Ready         out  1           store accepts Lookup/Write
//   Resp_Valid    out  1           Hit/Victim outputs valid (one cycle after accepted Lookup)
//   Hit           out  1           Tag_Cmp matched a valid way
//   Hit_Way       out  WAY_W       matching way (lowest index if several)
//   Hit_Dirty     out  1           dirty bit of matching way
//   Victim_Way    out  WAY_W       way to replace on miss
//   Victim_Tag    out  TAG_W       stored tag of Victim_Way (write-back address)
//   Victim_Dirty  out  1           Victim_Way valid and dirty (write-back needed)
// BEHAVIOUR
//   - FSM: SWEEP, READY. Reset -> SWEEP, sweep counter 0; all outputs 0 while reset low.
//   - SWEEP: each cycle write 0 to all ways at counter, clear its rr pointer, counter++;
//     after 2**INDEX_BITS cycles (counter wraps) -> READY. Ready=0 during SWEEP; Lookup/Write ignored.
//   - READY: Ready=1. Invalidate_All -> SWEEP from counter 0 (Ready=0 next cycle); a Write or
//     Lookup in the same cycle is dropped (Invalidate_All wins).
//   - Lookup accepted in cycle N (Ready=1, Write=0): RAM read; in N+1 Resp_Valid=1 and all result
//     outputs are combinational from RAM dout and Tag_Cmp. Resp_Valid=0 otherwise; result outputs
//     are don't-care when Resp_Valid=0 except at reset (0).
//   - Hit = OR over ways of (valid & tag==Tag_Cmp). Hit=0 -> Hit_Way=0, Hit_Dirty=0.
//   - Victim: lowest-numbered invalid way; if all valid, the set's rr pointer.
//     Victim_Dirty = valid & dirty of that way. WAYS=1 -> Victim_Way=0 always.
//   - Write accepted (Ready=1): single-cycle write to way Write_Way only; other ways untouched.
//     If Valid=1 and Write_Way==rr pointer of the set, pointer <= pointer+1 mod WAYS.
//   - Write and Lookup in the same cycle: Write wins, Lookup dropped (Resp_Valid=0 next cycle).
//   - Lookup the cycle after Write to same set returns the written data (no bypass needed: RAM read
//     occurs after the write cycle).
//   - rr pointers: registers, 2**INDEX_BITS x WAY_W, reset to 0 by async reset and by SWEEP.
//   - reset low mid-sweep or mid-lookup: immediate return to reset values; sweep restarts at 0.
// TESTING
//   1. Release reset -> Ready=0 for 256 cycles, 1 at cycle 256; Lookup idx 0x00 -> Resp_Valid=1, Hit=0, Victim_Way=0, Victim_Dirty=0.
//   2. Write idx 0x12 way1 tag 0xABCDEF V=1 D=1; Lookup 0x12, Tag_Cmp 0xABCDEF -> Hit=1, Hit_Way=1, Hit_Dirty=1; Tag_Cmp 0xABCDEE -> Hit=0, Victim_Way=0.
//   3. Fill idx 5 way0 tag 0x111 D=0, way1 tag 0x222 D=1 (pointer 0->1); Lookup miss -> Victim_Way=1, Victim_Tag=0x222, Victim_Dirty=1.
//   4. Invalidate_All with concurrent Write idx 7 -> Ready=0 for 256 cycles; then Lookup idx 0x12 and 7 -> Hit=0, Victim_Way=0.
//   5. Reset low at sweep counter 100 -> outputs 0; release -> Ready after exactly 256 cycles.
//   6. Write idx 3 and Lookup idx 3 same cycle -> Resp_Valid=0 next cycle; Lookup next cycle -> Hit=1 on new tag.

Source files
------------

// File: rtl/tag_flag_ram_assoc.sv
// rtl/tag_flag_ram_assoc.sv - N-way set-associative tag/valid/dirty store with victim select and invalidate sweep
module tag_flag_ram_assoc #(
    parameter int PABITS      = 36,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 4,
    parameter int WAYS        = 2,
    localparam int TAG_W      = PABITS - INDEX_BITS - OFFSET_BITS,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic                  i_lookup,
    input  logic [TAG_W-1:0]      i_tag_cmp,
    input  logic                  i_write,
    input  logic [WAY_W-1:0]      i_write_way,
    input  logic [TAG_W-1:0]      i_tag_set,
    input  logic                  i_valid,
    input  logic                  i_dirty,
    input  logic                  i_invalidate_all,
    output logic                  o_ready,
    output logic                  o_resp_valid,
    output logic                  o_hit,
    output logic [WAY_W-1:0]      o_hit_way,
    output logic                  o_hit_dirty,
    output logic [WAY_W-1:0]      o_victim_way,
    output logic [TAG_W-1:0]      o_victim_tag,
    output logic                  o_victim_dirty
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int ENT_W = TAG_W + 2;   // {valid, dirty, tag}

    typedef enum logic {ST_SWEEP, ST_READY} state_t;

    state_t                r_state;
    logic [INDEX_BITS-1:0] r_sweep_cnt;
    logic                  r_ready;
    logic                  r_resp_valid;
    logic [ENT_W-1:0]      r_mem  [WAYS][SETS];
    logic [ENT_W-1:0]      r_dout [WAYS];
    logic [WAY_W-1:0]      r_rr   [SETS];
    logic [WAY_W-1:0]      r_lk_rr;

    logic                  w_sweep;
    logic                  w_acc_write;
    logic                  w_acc_lookup;
    logic [WAY_W-1:0]      w_rr_next;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic                  w_hit_dirty;
    logic                  w_inv_found;
    logic [WAY_W-1:0]      w_victim_way;
    logic [TAG_W-1:0]      w_victim_tag;
    logic                  w_victim_dirty;

    // Invalidate_All beats Write, and Write beats Lookup.
    assign w_sweep      = (r_state == ST_SWEEP);
    assign w_acc_write  = r_ready & i_write & ~i_invalidate_all;
    assign w_acc_lookup = r_ready & i_lookup & ~i_write & ~i_invalidate_all;
    assign w_rr_next    = (WAYS == 1) ? '0 : r_rr[i_index] + WAY_W'(1);

    // Control FSM: sweep every set once, then serve requests until an invalidate restarts the sweep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_SWEEP;
            r_sweep_cnt  <= '0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= w_acc_lookup;
            case (r_state)
                ST_SWEEP: begin
                    r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    if (&r_sweep_cnt) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (i_invalidate_all) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_cnt <= '0;
                        r_ready     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SWEEP;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-way tag RAM write port; contents are cleared by the sweep, not by reset.
    always_ff @(posedge i_clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_sweep) begin
                r_mem[w][r_sweep_cnt] <= '0;
            end else if (w_acc_write && (i_write_way == WAY_W'(w))) begin
                r_mem[w][i_index] <= {i_valid, i_dirty, i_tag_set};
            end
        end
    end

    // Registered RAM read plus a snapshot of the set's replacement pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                r_dout[w] <= '0;
            end
            r_lk_rr <= '0;
        end else if (w_acc_lookup) begin
            for (int w = 0; w < WAYS; w++) begin
                r_dout[w] <= r_mem[w][i_index];
            end
            r_lk_rr <= r_rr[i_index];
        end
    end

    // Round-robin pointers advance only when the pointed-at way is filled with a valid line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else if (w_sweep) begin
            r_rr[r_sweep_cnt] <= '0;
        end else if (w_acc_write && i_valid && (i_write_way == r_rr[i_index])) begin
            r_rr[i_index] <= w_rr_next;
        end
    end

    // Parallel tag compare and victim choice: lowest matching way, lowest invalid way else rr pointer.
    always_comb begin
        w_hit          = 1'b0;
        w_hit_way      = '0;
        w_hit_dirty    = 1'b0;
        w_inv_found    = 1'b0;
        w_victim_way   = r_lk_rr;
        w_victim_tag   = '0;
        w_victim_dirty = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_dout[w][ENT_W-1] && (r_dout[w][TAG_W-1:0] == i_tag_cmp) && !w_hit) begin
                w_hit       = 1'b1;
                w_hit_way   = WAY_W'(w);
                w_hit_dirty = r_dout[w][TAG_W];
            end
            if (!r_dout[w][ENT_W-1] && !w_inv_found) begin
                w_inv_found  = 1'b1;
                w_victim_way = WAY_W'(w);
            end
        end
        if (WAYS == 1) begin
            w_victim_way = '0;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (w_victim_way == WAY_W'(w)) begin
                w_victim_tag   = r_dout[w][TAG_W-1:0];
                w_victim_dirty = r_dout[w][ENT_W-1] & r_dout[w][TAG_W];
            end
        end
    end

    assign o_ready        = r_ready;
    assign o_resp_valid   = r_resp_valid;
    assign o_hit          = w_hit;
    assign o_hit_way      = w_hit_way;
    assign o_hit_dirty    = w_hit_dirty;
    assign o_victim_way   = w_victim_way;
    assign o_victim_tag   = w_victim_tag;
    assign o_victim_dirty = w_victim_dirty;

endmodule

// File: tb/tb_tag_flag_ram_assoc.sv
// tb/tb_tag_flag_ram_assoc.sv - directed self-checking bench for tag_flag_ram_assoc
module tb_tag_flag_ram_assoc;

    logic        clk;
    logic        rst_n;
    logic [7:0]  index;
    logic        lookup;
    logic [23:0] tag_cmp;
    logic        write;
    logic [0:0]  write_way;
    logic [23:0] tag_set;
    logic        valid;
    logic        dirty;
    logic        inv_all;
    logic        ready;
    logic        resp_valid;
    logic        hit;
    logic [0:0]  hit_way;
    logic        hit_dirty;
    logic [0:0]  victim_way;
    logic [23:0] victim_tag;
    logic        victim_dirty;

    int total;
    int passed;

    tag_flag_ram_assoc dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_index          (index),
        .i_lookup         (lookup),
        .i_tag_cmp        (tag_cmp),
        .i_write          (write),
        .i_write_way      (write_way),
        .i_tag_set        (tag_set),
        .i_valid          (valid),
        .i_dirty          (dirty),
        .i_invalidate_all (inv_all),
        .o_ready          (ready),
        .o_resp_valid     (resp_valid),
        .o_hit            (hit),
        .o_hit_way        (hit_way),
        .o_hit_dirty      (hit_dirty),
        .o_victim_way     (victim_way),
        .o_victim_tag     (victim_tag),
        .o_victim_dirty   (victim_dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] idx, input logic [0:0] way, input logic [23:0] tag,
                            input logic v, input logic d);
        index = idx; write_way = way; tag_set = tag; valid = v; dirty = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic do_lookup(input logic [7:0] idx, input logic [23:0] tag);
        index = idx; lookup = 1'b1;
        tick();
        lookup = 1'b0;
        tag_cmp = tag;
        #1;
    endtask

    // Counts cycles until Ready rises, bounded.
    task automatic wait_ready(input string name, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 1000) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt !== exp_cycles) $display("FAIL %s: ready after %0d cycles, expected %0d", name, cnt, exp_cycles);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; index = '0; lookup = 0; tag_cmp = '0; write = 0; write_way = '0;
        tag_set = '0; valid = 0; dirty = 0; inv_all = 0;
        repeat (3) tick();
        total++;
        if ({ready, resp_valid, hit, victim_way, victim_dirty, victim_tag} !== 29'd0)
            $display("FAIL reset_outputs: got %h, expected 0", {ready, resp_valid, hit, victim_way, victim_dirty, victim_tag});
        else passed++;
        rst_n = 1'b1;
        wait_ready("initial_sweep", 256);
        do_lookup(8'h00, 24'h000000);
        total++;
        if ({resp_valid, hit, victim_way, victim_dirty} !== 4'b1000)
            $display("FAIL lookup_idx0: rv/hit/vway/vdirty=%b, expected 1000", {resp_valid, hit, victim_way, victim_dirty});
        else passed++;
    endtask

    task automatic test_hit();
        do_write(8'h12, 1'b1, 24'hABCDEF, 1'b1, 1'b1);
        do_lookup(8'h12, 24'hABCDEF);
        total++;
        if ({resp_valid, hit, hit_way, hit_dirty} !== 4'b1111)
            $display("FAIL hit_way1: rv/hit/way/dirty=%b, expected 1111", {resp_valid, hit, hit_way, hit_dirty});
        else passed++;
        do_lookup(8'h12, 24'hABCDEE);
        total++;
        if ({resp_valid, hit, hit_way, hit_dirty, victim_way, victim_dirty} !== 6'b100000)
            $display("FAIL miss_tag: rv/hit/way/dirty/vway/vdirty=%b, expected 100000",
                     {resp_valid, hit, hit_way, hit_dirty, victim_way, victim_dirty});
        else passed++;
    endtask

    task automatic test_victim();
        // way1 first (pointer stays 0), then way0 (pointer 0->1)
        do_write(8'h05, 1'b1, 24'h000222, 1'b1, 1'b1);
        do_write(8'h05, 1'b0, 24'h000111, 1'b1, 1'b0);
        do_lookup(8'h05, 24'h000333);
        total++;
        if ({hit, victim_way, victim_dirty} !== 3'b011 || victim_tag !== 24'h000222)
            $display("FAIL rr_victim: hit/vway/vdirty=%b tag=%h, expected 011 tag=000222",
                     {hit, victim_way, victim_dirty}, victim_tag);
        else passed++;
        do_lookup(8'h05, 24'h000111);
        total++;
        if ({hit, hit_way, hit_dirty} !== 3'b100)
            $display("FAIL hit_way0: hit/way/dirty=%b, expected 100", {hit, hit_way, hit_dirty});
        else passed++;
    endtask

    task automatic test_invalidate();
        inv_all = 1'b1;
        index = 8'h07; write_way = 1'b0; tag_set = 24'h000777; valid = 1'b1; dirty = 1'b1; write = 1'b1;
        tick();
        inv_all = 1'b0; write = 1'b0;
        total++;
        if (ready !== 1'b0) $display("FAIL inv_ready_drop: ready=%b, expected 0", ready);
        else passed++;
        wait_ready("inv_sweep", 256);
        do_lookup(8'h12, 24'hABCDEF);
        total++;
        if ({resp_valid, hit, victim_way, victim_dirty} !== 4'b1000)
            $display("FAIL inv_idx12: rv/hit/vway/vdirty=%b, expected 1000", {resp_valid, hit, victim_way, victim_dirty});
        else passed++;
        do_lookup(8'h07, 24'h000777);
        total++;
        if ({resp_valid, hit, victim_way, victim_dirty} !== 4'b1000)
            $display("FAIL inv_idx7: rv/hit/vway/vdirty=%b, expected 1000", {resp_valid, hit, victim_way, victim_dirty});
        else passed++;
        do_lookup(8'h05, 24'h000111);
        total++;
        if ({hit, victim_way, victim_dirty} !== 3'b000)
            $display("FAIL inv_idx5_rr: hit/vway/vdirty=%b, expected 000", {hit, victim_way, victim_dirty});
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_write(8'h09, 1'b0, 24'h000999, 1'b1, 1'b1);
        do_lookup(8'h09, 24'h000999);
        total++;
        if ({resp_valid, hit, hit_dirty} !== 3'b111)
            $display("FAIL pre_reset_hit: rv/hit/dirty=%b, expected 111", {resp_valid, hit, hit_dirty});
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, resp_valid, hit, hit_dirty, victim_dirty, victim_tag} !== 29'd0)
            $display("FAIL reset_mid_lookup: got %h, expected 0", {ready, resp_valid, hit, hit_dirty, victim_dirty, victim_tag});
        else passed++;
        tick();
        rst_n = 1'b1;
        wait_ready("sweep_after_lookup_reset", 256);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, resp_valid, hit, victim_way, victim_dirty, victim_tag} !== 29'd0)
            $display("FAIL reset_mid_sweep: got %h, expected 0", {ready, resp_valid, hit, victim_way, victim_dirty, victim_tag});
        else passed++;
        tick();
        rst_n = 1'b1;
        wait_ready("sweep_restart", 256);
        do_lookup(8'h09, 24'h000999);
        total++;
        if ({resp_valid, hit} !== 2'b10)
            $display("FAIL post_reset_idx9: rv/hit=%b, expected 10", {resp_valid, hit});
        else passed++;
    endtask

    task automatic test_back_to_back();
        index = 8'h03; write_way = 1'b0; tag_set = 24'h000333; valid = 1'b1; dirty = 1'b0;
        write = 1'b1; lookup = 1'b1;
        tick();
        write = 1'b0; lookup = 1'b0;
        total++;
        if (resp_valid !== 1'b0) $display("FAIL write_lookup_collide: resp_valid=%b, expected 0", resp_valid);
        else passed++;
        do_lookup(8'h03, 24'h000333);
        total++;
        if ({resp_valid, hit, hit_way, hit_dirty} !== 4'b1100)
            $display("FAIL lookup_after_write: rv/hit/way/dirty=%b, expected 1100", {resp_valid, hit, hit_way, hit_dirty});
        else passed++;
        do_write(8'h05, 1'b1, 24'h000222, 1'b1, 1'b1);
        // consecutive lookups: idx 3 then idx 5
        index = 8'h03; lookup = 1'b1;
        tick();
        index = 8'h05; tag_cmp = 24'h000333;
        #1;
        total++;
        if ({resp_valid, hit, hit_way} !== 3'b110)
            $display("FAIL b2b_first: rv/hit/way=%b, expected 110", {resp_valid, hit, hit_way});
        else passed++;
        tick();
        lookup = 1'b0; tag_cmp = 24'h000222;
        #1;
        total++;
        if ({resp_valid, hit, hit_way, hit_dirty} !== 4'b1111)
            $display("FAIL b2b_second: rv/hit/way/dirty=%b, expected 1111", {resp_valid, hit, hit_way, hit_dirty});
        else passed++;
        tick();
        total++;
        if (resp_valid !== 1'b0) $display("FAIL resp_valid_idle: resp_valid=%b, expected 0", resp_valid);
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_hit();
        test_victim();
        test_invalidate();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
